// File: rtl/display_spi_receiver_pkg.sv
// Shared constants and state encoding for the display SPI receiver.
package display_spi_receiver_pkg;

  localparam int unsigned ByteWidth        = 8;
  localparam int unsigned DefaultFifoDepth = 4;
  localparam int unsigned BitCntWidth      = $clog2(ByteWidth);

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head entry.
// The head output always reflects the oldest entry.
module sync_fifo import display_spi_receiver_pkg::*; #(
  parameter int unsigned DEPTH = DefaultFifoDepth,
  parameter int unsigned WIDTH = ByteWidth + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned     PtrW    = $clog2(DEPTH);
  localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]   OneCnt  = (PtrW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q, rptr_nxt;
  logic [PtrW:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCnt);
  assign pop_ok   = pop && !empty;
  // A pop frees the slot, so a push into a full FIFO still succeeds in that cycle.
  assign push_ok  = push && (!full || pop_ok);
  assign rptr_nxt = rptr_q + 1'b1;
  assign rdata    = head_q;

  // Next occupancy and next head entry.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Incoming data becomes head directly when nothing older remains.
    if (push_ok && (empty || (pop_ok && count_q == OneCnt))) begin
      head_d = wdata;
    end else if (pop_ok && count_q != OneCnt) begin
      head_d = mem_q[rptr_nxt];
    end
  end

  // Storage array; contents only matter behind valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_nxt;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/display_spi_receiver.sv
// SPI mode-0 receiver for a display command/data stream.
// Bytes are tagged with dc and queued for the consumer.
module display_spi_receiver import display_spi_receiver_pkg::*; #(
  parameter int unsigned FIFO_DEPTH  = DefaultFifoDepth,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs,
  input  logic                 dc,
  input  logic                 mosi,
  output logic [ByteWidth-1:0] outData,
  output logic                 outIsData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 frameErr,
  output logic                 overflow,
  input  logic                 clearErr
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, dc_sync_q, mosi_sync_q;
  logic                   sclk_s, cs_s, dc_s, mosi_s;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_rise, cs_fall, cs_rise;

  rx_state_e              state_q, state_d;
  logic [BitCntWidth-1:0] bit_cnt_q, bit_cnt_d;
  // Holds the first seven bits; the eighth comes straight from mosi at push time.
  logic [ByteWidth-2:0]   shreg_q, shreg_d;
  logic                   push, frame_set, ovf_set;
  logic                   frame_err_q, overflow_q;

  logic [ByteWidth:0]     fifo_rdata;
  logic                   fifo_empty, fifo_full, fifo_pop;

  // Synchronizer chains, reset to the idle bus levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      dc_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q[0] <= sclk;
      cs_sync_q[0]   <= cs;
      dc_sync_q[0]   <= dc;
      mosi_sync_q[0] <= mosi;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        cs_sync_q[i]   <= cs_sync_q[i-1];
        dc_sync_q[i]   <= dc_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign dc_s   = dc_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Previous synchronized samples for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s && !sclk_prev_q;
  assign cs_fall   = !cs_s && cs_prev_q;
  assign cs_rise   = cs_s && !cs_prev_q;

  // Receive FSM: frame tracking, bit shifting and byte push.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d   = StIdle;
          frame_set = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          shreg_d   = '0;
        end else if (sclk_rise && !cs_s) begin
          shreg_d   = {shreg_q[ByteWidth-3:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          push      = (bit_cnt_q == BitCntWidth'(ByteWidth - 1));
        end
      end
    endcase
  end

  // FSM, bit counter and shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  assign fifo_pop = !fifo_empty && outReady;
  assign ovf_set  = push && fifo_full && !fifo_pop;

  // Sticky error flags; a new set event beats clearErr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (frame_set)     frame_err_q <= 1'b1;
      else if (clearErr) frame_err_q <= 1'b0;
      if (ovf_set)       overflow_q  <= 1'b1;
      else if (clearErr) overflow_q  <= 1'b0;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ByteWidth + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({dc_s, shreg_q, mosi_s}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign outData   = fifo_rdata[ByteWidth-1:0];
  assign outIsData = fifo_rdata[ByteWidth];
  assign outValid  = !fifo_empty;
  assign frameErr  = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_display_spi_receiver.sv
// Randomized bench for display_spi_receiver against a queue-based reference.
module tb_display_spi_receiver;

  localparam int unsigned Depth = 4;
  localparam int unsigned Sync  = 2;

  logic       clk, rst_n, sclk, cs, dc, mosi;
  logic [7:0] outData;
  logic       outIsData, outValid, outReady, frameErr, overflow, clearErr;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: queue of {dc, byte}, plus sticky flags.
  logic [8:0] mq[$];
  logic       m_ferr, m_ovf;

  display_spi_receiver #(
    .FIFO_DEPTH  (Depth),
    .SYNC_STAGES (Sync)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs        (cs),
    .dc        (dc),
    .mosi      (mosi),
    .outData   (outData),
    .outIsData (outIsData),
    .outValid  (outValid),
    .outReady  (outReady),
    .frameErr  (frameErr),
    .overflow  (overflow),
    .clearErr  (clearErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input logic dcv);
    if (mq.size() < Depth) mq.push_back({dcv, d});
    else m_ovf = 1'b1;
  endtask

  // Shift nbits of data MSB first; optionally pulse outReady in the push cycle of bit 8.
  task automatic spi_bits(input logic [7:0] data, input logic dcv, input int nbits,
                          input bit pop_last);
    logic [7:0] v;
    v = data;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      mosi = v[7-i];
      dc   = dcv;
      repeat (3) @(posedge clk);
      #1 sclk = 1'b1;
      if (pop_last && i == 7) begin
        repeat (Sync) @(posedge clk);
        #1 outReady = 1'b1;
        @(posedge clk);
        #1 outReady = 1'b0;
        repeat (2) @(posedge clk);
      end else begin
        repeat (4) @(posedge clk);
      end
      #1 sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic dcv);
    spi_bits(d, dcv, 8, 1'b0);
    model_byte(d, dcv);
  endtask

  task automatic cs_low();
    @(posedge clk); #1 cs = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(posedge clk);
    #1 cs = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic check_flags();
    @(negedge clk);
    check_eq("frameErr", frameErr, m_ferr);
    check_eq("overflow", overflow, m_ovf);
    check_eq("outValid", outValid, mq.size() != 0);
  endtask

  task automatic clear_errs();
    @(negedge clk) clearErr = 1'b1;
    @(posedge clk); #1 clearErr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic drain();
    logic [8:0] head;
    while (mq.size() > 0) begin
      head = mq[0];
      @(negedge clk);
      check_eq("outValid_head", outValid, 1);
      check_eq("outData", outData, head[7:0]);
      check_eq("outIsData", outIsData, head[8]);
      outReady = 1'b1;
      @(posedge clk); #1 outReady = 1'b0;
      void'(mq.pop_front());
    end
    @(negedge clk);
    check_eq("outValid_empty", outValid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_outValid"}, outValid, 0);
    check_eq({tag, "_outData"}, outData, 0);
    check_eq({tag, "_outIsData"}, outIsData, 0);
    check_eq({tag, "_frameErr"}, frameErr, 0);
    check_eq({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int         n, k;
    logic [7:0] d;
    logic       dv;

    rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; dc = 1'b0; mosi = 1'b0;
    outReady = 1'b0; clearErr = 1'b0;
    m_ferr = 1'b0; m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single data byte.
    cs_low();
    send_byte(8'hAA, 1'b1);
    check_flags();
    drain();
    cs_high();
    check_flags();

    // Back-to-back command bytes in one frame.
    cs_low();
    send_byte(8'h33, 1'b0);
    send_byte(8'hB6, 1'b0);
    cs_high();
    check_flags();
    drain();

    // Aborted frame after three bits, then a clean byte.
    cs_low();
    spi_bits(8'h55, 1'b1, 3, 1'b0);
    cs_high();
    m_ferr = 1'b1;
    check_flags();
    cs_low();
    send_byte(8'hB6, 1'b1);
    cs_high();
    check_flags();
    drain();
    clear_errs();
    check_flags();

    // Overflow with the consumer stalled, then clear.
    cs_low();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    cs_high();
    check_flags();
    clear_errs();
    check_flags();
    drain();

    // Full FIFO: pop and push land in the same cycle.
    cs_low();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    spi_bits(8'h05, 1'b1, 8, 1'b1);
    void'(mq.pop_front());
    model_byte(8'h05, 1'b1);
    cs_high();
    check_flags();
    drain();

    // Reset mid-byte with a full FIFO and overflow pending.
    cs_low();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'($urandom_range(0, 1)));
    spi_bits(8'($urandom), 1'b1, 5, 1'b0);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    mq.delete();
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    cs_high();
    check_flags();
    cs_low();
    send_byte(8'h3C, 1'b0);
    cs_high();
    check_flags();
    drain();

    // Randomized frames: random length, data, dc and optional abort.
    repeat (8) begin
      n = $urandom_range(1, 6);
      cs_low();
      for (int j = 0; j < n; j++) begin
        d  = 8'($urandom);
        dv = 1'($urandom_range(0, 1));
        send_byte(d, dv);
      end
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 7);
        spi_bits(8'($urandom), 1'b0, k, 1'b0);
        m_ferr = 1'b1;
      end
      cs_high();
      check_flags();
      drain();
      clear_errs();
      check_flags();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
